// File: rtl/parity_pkg.sv
// Shared lane-width derivation and parameter sanity checks for the parity stream.
package parity_pkg;

    function automatic int unsigned lane_width(input int unsigned width, input int unsigned lanes);
        return width / lanes;
    endfunction

    function automatic bit lanes_divide(input int unsigned width, input int unsigned lanes);
        return (lanes != 0) && ((width % lanes) == 0);
    endfunction

endpackage

// File: rtl/parity_lane.sv
// Parity of one lane: XOR-reduce of LW bits, inverted when odd parity is selected.
module parity_lane #(
    parameter int unsigned LW = 8
) (
    input  logic [LW-1:0] lane_data,
    input  logic          odd,
    output logic          par
);

    always_comb begin
        par = (^lane_data) ^ odd;
    end

endmodule

// File: rtl/parity_stream.sv
// Two-stage valid/ready pipeline computing per-lane parity, optional checking
// against received parity, and a saturating mismatch counter.
module parity_stream
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_odd,
    input  logic             check_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LANES-1:0] in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LANES-1:0] out_par,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    localparam int unsigned LW = lane_width(WIDTH, LANES);

    if (!lanes_divide(WIDTH, LANES)) begin : g_width_check
        $error("parity_stream: WIDTH must be a non-zero multiple of LANES");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [LANES-1:0] s1_par_in;
    logic             s1_odd;
    logic             s1_chk;
    logic [LANES-1:0] lane_par;
    logic             s1_err;
    logic             s2_adv;
    logic             s1_load;
    logic             out_fire;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane #(.LW(LW)) u_lane (
            .lane_data (s1_data[i*LW +: LW]),
            .odd       (s1_odd),
            .par       (lane_par[i])
        );
    end

    // S1 may reload when empty or when its word moves into S2 this cycle.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_adv;
        in_ready = !rst && s1_load;
        out_fire = out_valid && out_ready;
        s1_err   = s1_chk ? |(lane_par ^ s1_par_in) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data   <= in_data;
                    s1_par_in <= in_par;
                    s1_odd    <= mode_odd;
                    s1_chk    <= check_en;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s1_data;
                    out_par  <= lane_par;
                    out_err  <= s1_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            err_count <= '0;
        end else if (out_fire && out_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
